// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        DM_BUSY
    } arb_state_t;

    typedef enum logic {
        GNT_IF,
        GNT_DM
    } grant_t;

    localparam int unsigned TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side (fetch/data) and memory-side signal bundle for mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_valid;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    logic                  stall_if;
    logic                  stall_dm;
    logic                  err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_valid, dm_rdata, dm_valid,
        output mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_dm, err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_valid, dm_rdata, dm_valid,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall_if, stall_dm, err
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle counter for the outstanding memory access; expired_o flags the
// waiting cycle that brings the count to TIMEOUT.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    // Abort lands on the TIMEOUT-th waiting cycle, so mem_req is held for exactly TIMEOUT cycles.
    assign expired_o = en_i && (count_q == CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i || expired_o) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages with timeout abort.
// Optional round-robin on contested grants: define MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    arb_state_t            state_q, state_d;
    grant_t                gnt;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  dm_valid_q, dm_valid_d;
    logic                  err_q, err_d;
    logic                  if_elig, dm_elig;
    logic                  wd_clr, wd_en, wd_expired;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic                  prio_if_q, prio_if_d;
`endif

    // A requester whose valid pulse is out this cycle is still holding req; skip it.
    assign if_elig = bus.if_req && !if_valid_q;
    assign dm_elig = bus.dm_req && !dm_valid_q;

    assign wd_en  = (state_q != IDLE) && mem_req_q && !bus.mem_ack;
    assign wd_clr = (state_q == IDLE) || bus.mem_ack;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (wd_clr),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (if_elig && dm_elig) begin
            gnt = prio_if_q ? GNT_IF : GNT_DM;
        end else begin
            gnt = dm_elig ? GNT_DM : GNT_IF;
        end
`else
        gnt = dm_elig ? GNT_DM : GNT_IF;
`endif
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        err_d       = err_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_if_d   = prio_if_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_elig || dm_elig) begin
                    mem_req_d = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    if (if_elig && dm_elig) begin
                        prio_if_d = !prio_if_q;
                    end
`endif
                    if (gnt == GNT_DM) begin
                        state_d     = DM_BUSY;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        state_d     = IF_BUSY;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                    end
                end
            end
            IF_BUSY, DM_BUSY: begin
                if (bus.mem_ack || wd_expired) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    if (!bus.mem_ack) begin
                        err_d = 1'b1;
                    end
                    if (state_q == IF_BUSY) begin
                        if_valid_d = 1'b1;
                        if_rdata_d = bus.mem_ack ? bus.mem_rdata : '0;
                    end else begin
                        dm_valid_d = 1'b1;
                        if (!bus.mem_ack) begin
                            dm_rdata_d = '0;
                        end else if (!mem_we_q) begin
                            dm_rdata_d = bus.mem_rdata;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            err_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_if_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            err_q       <= err_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            prio_if_q   <= prio_if_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.dm_valid  = dm_valid_q;
    assign bus.err       = err_q;
    assign bus.stall_if  = bus.if_req && !if_valid_q;
    assign bus.stall_dm  = bus.dm_req && !dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT=4); honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          dm;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mrdata;
        int unsigned k;          // ack on k-th cycle of mem_req; 0 = never
        logic [31:0] exp_rdata;  // requester's rdata after completion
        bit          exp_err;
    } vec_t;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Reference state: what each requester should hold, sticky error, contested-priority memory.
    logic [31:0] m_if_rdata, m_dm_rdata;
    bit          m_err;
    bit          m_next_contest_if;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_if_rdata        = '0;
        m_dm_rdata        = '0;
        m_err             = 1'b0;
        m_next_contest_if = 1'b0;
    endtask

    task automatic model_pick(input bit if_p, input bit dm_p, output bit first_dm);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (if_p && dm_p) begin
            first_dm          = !m_next_contest_if;
            m_next_contest_if = !m_next_contest_if;
        end else begin
            first_dm = dm_p;
        end
`else
        first_dm = dm_p || !if_p;
`endif
    endtask

    task automatic clear_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = '0;
        bus.dm_wdata  = '0;
        bus.mem_rdata = '0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {bus.mem_req, bus.mem_we, bus.if_valid, bus.dm_valid,
                            bus.err, bus.stall_if, bus.stall_dm}, '0);
        chk({tag, "_maddr"}, bus.mem_addr, '0);
        chk({tag, "_mwdata"}, bus.mem_wdata, '0);
        chk({tag, "_ifrd"}, bus.if_rdata, '0);
        chk({tag, "_dmrd"}, bus.dm_rdata, '0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_req"}, bus.mem_req, 1'b0);
        chk({tag, "_valid"}, {bus.if_valid, bus.dm_valid}, 2'b00);
    endtask

    // Grant happens on the next edge; requester's req/fields must already be driven.
    task automatic serve(input bit is_dm, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mrdata,
                         input int unsigned k);
        bit timed_out;
        timed_out = (k == 0) || (k > TO);
        tick();
        chk("grant_req", bus.mem_req, 1'b1);
        chk("grant_we", bus.mem_we, is_dm ? we : 1'b0);
        chk("grant_addr", bus.mem_addr, addr);
        if (is_dm) chk("grant_wdata", bus.mem_wdata, wdata);
        chk("grant_stall", is_dm ? bus.stall_dm : bus.stall_if, 1'b1);
        for (int unsigned c = 1; c <= TO; c++) begin
            if (c == k) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mrdata;
            end else begin
                bus.mem_rdata = $urandom;
            end
            tick();
            bus.mem_ack = 1'b0;
            if (c == k || c == TO) break;
            chk("wait_req", bus.mem_req, 1'b1);
            chk("wait_valid", {bus.if_valid, bus.dm_valid}, 2'b00);
            chk("wait_stall", is_dm ? bus.stall_dm : bus.stall_if, 1'b1);
        end
        if (timed_out) begin
            m_err = 1'b1;
            if (is_dm) m_dm_rdata = '0; else m_if_rdata = '0;
        end else if (!is_dm) begin
            m_if_rdata = mrdata;
        end else if (!we) begin
            m_dm_rdata = mrdata;
        end
        chk("done_valid", {bus.if_valid, bus.dm_valid}, is_dm ? 2'b01 : 2'b10);
        chk("done_req", bus.mem_req, 1'b0);
        chk("done_ifrd", bus.if_rdata, m_if_rdata);
        chk("done_dmrd", bus.dm_rdata, m_dm_rdata);
        chk("done_err", bus.err, m_err);
        chk("done_stall", is_dm ? bus.stall_dm : bus.stall_if, 1'b0);
        if (is_dm) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
    endtask

    task automatic contested_round(input bit if_p, input bit dm_p, input bit dwe,
                                   input logic [31:0] daddr, input logic [31:0] dwdata,
                                   input logic [31:0] iaddr);
        bit first_dm;
        int unsigned kd, ki;
        logic [31:0] rd_d, rd_i;
        kd   = $urandom_range(1, TO + 1);
        ki   = $urandom_range(1, TO + 1);
        rd_d = $urandom;
        rd_i = $urandom;
        bus.if_req   = if_p;
        bus.if_addr  = iaddr;
        bus.dm_req   = dm_p;
        bus.dm_we    = dwe;
        bus.dm_addr  = daddr;
        bus.dm_wdata = dwdata;
        model_pick(if_p, dm_p, first_dm);
        if (first_dm) begin
            serve(1'b1, dwe, daddr, dwdata, rd_d, kd);
            if (if_p) serve(1'b0, 1'b0, iaddr, '0, rd_i, ki);
        end else begin
            serve(1'b0, 1'b0, iaddr, '0, rd_i, ki);
            if (dm_p) serve(1'b1, dwe, daddr, dwdata, rd_d, kd);
        end
        tick();
        check_idle("round_end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t tbl[6];
        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, 32'h00A0_0093, 3, 32'h00A0_0093, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0, 32'h1234_5678, 1, 32'h1234_5678, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 2, 32'h1234_5678, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 32'h0000_0013, TO, 32'h0000_0013, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'hAAAA_5555, 0, 32'h0000_0000, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_0108, 32'h0, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 1'b1};

        model_reset();
        do_reset();
        check_all_zero("reset");

        // Stray ack while idle must be ignored.
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h55AA_55AA;
        tick();
        bus.mem_ack = 1'b0;
        check_all_zero("stray_ack");

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].dm) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = tbl[i].we;
                bus.dm_addr  = tbl[i].addr;
                bus.dm_wdata = tbl[i].wdata;
            end else begin
                bus.if_req  = 1'b1;
                bus.if_addr = tbl[i].addr;
            end
            serve(tbl[i].dm, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].mrdata, tbl[i].k);
            chk("tbl_rdata", tbl[i].dm ? bus.dm_rdata : bus.if_rdata, tbl[i].exp_rdata);
            chk("tbl_err", bus.err, tbl[i].exp_err);
            tick();
            check_idle("tbl_after");
            chk("tbl_err_sticky", bus.err, tbl[i].exp_err);
        end

        // Reset one cycle into IF_BUSY, then a late ack: access abandoned.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        tick();
        chk("rstmid_grant", bus.mem_req, 1'b1);
        tick();
        rst        = 1'b1;
        bus.if_req = 1'b0;
        tick();
        rst           = 1'b0;
        model_reset();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_0BAD;
        tick();
        bus.mem_ack = 1'b0;
        check_all_zero("rstmid_ack");
        tick();
        check_all_zero("rstmid_after");

        // Contested rounds from reset; first one is the fixed-priority store case.
        contested_round(1'b1, 1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0000_0300);
        for (int r = 1; r < 4; r++) begin
            contested_round(1'b1, 1'b1, 1'($urandom), $urandom, $urandom, $urandom);
        end

        for (int r = 0; r < 40; r++) begin
            int unsigned mask;
            mask = $urandom_range(1, 3);
            contested_round(mask[0], mask[1], 1'($urandom), $urandom, $urandom, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
